fifo_uart_tx: RTL and testbench

Serial transmitter that drains the 8-bit byte FIFO from its read side. It pops one byte at a time using the FIFO's deq/empty/data_out interface. Each byte goes out as an asynchronous serial frame: start bit, 8 data bits LSB first, then stop bit. It sits between the byte FIFO and the board-level TX pin, and is the sole consumer of the FIFO's dequeue port.

---
 rtl/fifo_uart_tx_pkg.sv | 22 ++
 rtl/fifo_uart_tx_baud.sv | 41 ++++
 rtl/fifo_uart_tx.sv | 188 ++++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_tx_pkg.sv
// fifo_uart_tx_pkg: shared state encoding and frame constants for the FIFO-fed
// UART transmitter.
// Optional feature macro: FIFO_UART_TX_PARITY_EN (adds an even-parity bit).
package fifo_uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_POP    = 3'd1,
        ST_LOAD   = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
        ST_STOP   = 3'd5,
        ST_PARITY = 3'd6
    } tx_state_e;

`ifdef FIFO_UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

endpackage

// File: rtl/fifo_uart_tx_baud.sv
// fifo_uart_tx_baud: bit-period counter. Counts 0..CLKS_PER_BIT-1 while run is
// high and pulses tick on the terminal count; held at zero while run is low.
module fifo_uart_tx_baud #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = run && (cnt_q == LAST);

    // Next count: wrap at the terminal count, park at zero when not running.
    always_comb begin
        cnt_d = cnt_q;
        if (!run) begin
            cnt_d = {CW{1'b0}};
        end else if (cnt_q == LAST) begin
            cnt_d = {CW{1'b0}};
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from the byte FIFO and sends each as an 8N1 frame
// (start, data LSB first, stop). Every output except the empty-gated deq
// strobe comes straight from a flop.
// Optional feature macro: FIFO_UART_TX_PARITY_EN inserts an even-parity bit
// between the last data bit and the stop bit.
import fifo_uart_tx_pkg::*;

module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              fifo_empty,
    output logic              fifo_deq,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              tx,
    output logic              busy,
    output logic              tx_done
);

    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              deq_q, deq_d;
    logic              frame_end_q, frame_end_d;
    logic              tx_done_q, tx_done_d;
    logic              baud_run_s;
    logic              baud_tick_s;

`ifdef FIFO_UART_TX_PARITY_EN
    logic              par_q, par_d;

    function automatic logic even_parity(input logic [DATA_W-1:0] b);
        return ^b;
    endfunction
`endif

    assign baud_run_s = (state_q == ST_START) || (state_q == ST_DATA) ||
                        (state_q == ST_STOP)  || (state_q == ST_PARITY);

    fifo_uart_tx_baud #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .reset (reset),
        .run   (baud_run_s),
        .tick  (baud_tick_s)
    );

    // The strobe is registered on entry to POP; gating with the live empty
    // flag keeps a FIFO reset during POP from producing an illegal dequeue.
    assign fifo_deq = deq_q && !fifo_empty;
    assign tx       = tx_q;
    assign busy     = busy_q;
    assign tx_done  = tx_done_q;

    // Next-state, datapath and next-output logic; tx_d follows state_d so the
    // registered tx lines up with the state it belongs to.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        tx_d        = tx_q;
        deq_d       = 1'b0;
        frame_end_d = 1'b0;
        // frame_end_q marks the first IDLE cycle after STOP; registering it
        // puts tx_done in the following cycle, which coincides with the POP
        // of a queued next byte.
        tx_done_d   = frame_end_q;
`ifdef FIFO_UART_TX_PARITY_EN
        par_d       = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (enable && !fifo_empty) begin
                    state_d = ST_POP;
                    deq_d   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_POP: begin
                tx_d = 1'b1;
                if (fifo_empty) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                shreg_d   = fifo_data;
                bit_cnt_d = {BW{1'b0}};
`ifdef FIFO_UART_TX_PARITY_EN
                par_d     = even_parity(fifo_data);
`endif
                tx_d      = 1'b0;
                state_d   = ST_START;
            end
            ST_START: begin
                if (baud_tick_s) begin
                    state_d = ST_DATA;
                    tx_d    = shreg_q[0];
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (baud_tick_s) begin
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        state_d = ST_PARITY;
                        tx_d    = par_q;
`else
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        shreg_d   = {1'b0, shreg_q[DATA_W-1:1]};
                        tx_d      = shreg_q[1];
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (baud_tick_s) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (baud_tick_s) begin
                    state_d     = ST_IDLE;
                    tx_d        = 1'b1;
                    frame_end_d = 1'b1;
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State, datapath and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            shreg_q     <= {DATA_W{1'b0}};
            bit_cnt_q   <= {BW{1'b0}};
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            deq_q       <= 1'b0;
            frame_end_q <= 1'b0;
            tx_done_q   <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            deq_q       <= deq_d;
            frame_end_q <= frame_end_d;
            tx_done_q   <= tx_done_d;
`ifdef FIFO_UART_TX_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed self-checking bench for fifo_uart_tx with
// CLKS_PER_BIT=4. A queue models the byte FIFO (registered read data).
module tb_fifo_uart_tx;

    localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int F = NB * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       fifo_empty = 1'b1;
    logic       fifo_deq;
    logic [7:0] fifo_data = 8'h00;
    logic       tx;
    logic       busy;
    logic       tx_done;

    int errors = 0;
    int checks = 0;

    logic [7:0] q[$];
    logic log_tx   [0:255];
    logic log_busy [0:255];
    logic log_deq  [0:255];
    logic log_done [0:255];

    always #5 clk = ~clk;

    fifo_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .DATA_W(8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_deq   (fifo_deq),
        .fifo_data  (fifo_data),
        .tx         (tx),
        .busy       (busy),
        .tx_done    (tx_done)
    );

    // Expected level of frame bit i for byte b.
    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        else if (i <= 8) return b[i-1];
        else if (NB == 11 && i == 9) return ^b;
        else return 1'b1;
    endfunction

    // One clock cycle: sample mid-cycle, then update the FIFO model after the edge.
    task automatic step(input int idx);
        logic deq_seen;
        @(negedge clk);
        if (idx >= 0) begin
            log_tx[idx]   = tx;
            log_busy[idx] = busy;
            log_deq[idx]  = fifo_deq;
            log_done[idx] = tx_done;
        end
        deq_seen = fifo_deq;
        @(posedge clk);
        #1;
        if (deq_seen && q.size() > 0) fifo_data = q.pop_front();
        fifo_empty = (q.size() == 0);
    endtask

    task automatic run_log(input int n, input int en_off, input int en_on, input int rst_at);
        for (int c = 0; c < n; c++) begin
            if (c == en_off) enable = 1'b0;
            if (c == en_on) enable = 1'b1;
            reset = (c == rst_at);
            step(c);
        end
        reset = 1'b0;
    endtask

    task automatic do_reset();
        enable = 1'b0;
        reset  = 1'b1;
        q.delete();
        fifo_empty = 1'b1;
        step(-1);
        step(-1);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        enable = 1'b0;
        fifo_empty = 1'b1;
        reset = 1'b1;
        step(0);
        step(1);
        reset = 1'b0;
        checks++; if (log_tx[1] !== 1'b1) begin errors++; $display("FAIL reset_tx got=%b exp=1", log_tx[1]); end
        checks++; if (log_busy[1] !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", log_busy[1]); end
        checks++; if (log_deq[1] !== 1'b0) begin errors++; $display("FAIL reset_deq got=%b exp=0", log_deq[1]); end
        checks++; if (log_done[1] !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", log_done[1]); end
    endtask

    task automatic test_single();
        int nd, nt;
        logic ok;
        do_reset();
        q.push_back(8'hA5);
        fifo_empty = 1'b0;
        enable = 1'b1;
        run_log(F + 10, -1, -1, -1);
        nd = 0; nt = 0;
        for (int c = 0; c < F + 10; c++) begin nd += int'(log_deq[c]); nt += int'(log_done[c]); end
        checks++; if (nd !== 1 || log_deq[1] !== 1'b1) begin errors++; $display("FAIL single_deq count=%0d at1=%b exp count=1 at1=1", nd, log_deq[1]); end
        checks++; if (log_tx[0] !== 1'b1 || log_tx[1] !== 1'b1 || log_tx[2] !== 1'b1) begin errors++; $display("FAIL single_pre_idle tx=%b%b%b exp=111", log_tx[0], log_tx[1], log_tx[2]); end
        for (int b = 0; b < NB; b++) begin
            ok = 1'b1;
            for (int k = 0; k < CPB; k++) if (log_tx[3 + b*CPB + k] !== frame_bit(8'hA5, b)) ok = 1'b0;
            checks++; if (!ok) begin errors++; $display("FAIL single_tx_bit%0d got=%b exp=%b", b, log_tx[3 + b*CPB], frame_bit(8'hA5, b)); end
        end
        checks++; if (nt !== 1 || log_done[F + 4] !== 1'b1) begin errors++; $display("FAIL single_done count=%0d atF+4=%b exp count=1 at=1", nt, log_done[F + 4]); end
        ok = 1'b1;
        for (int c = 1; c <= F + 2; c++) if (log_busy[c] !== 1'b1) ok = 1'b0;
        checks++; if (!ok || log_busy[0] !== 1'b0 || log_busy[F + 3] !== 1'b0) begin errors++; $display("FAIL single_busy window_ok=%b first=%b after=%b exp 1,0,0", ok, log_busy[0], log_busy[F + 3]); end
    endtask

    task automatic test_back_to_back();
        int nd, nt;
        logic ok;
        do_reset();
        q.push_back(8'h00);
        q.push_back(8'hFF);
        fifo_empty = 1'b0;
        enable = 1'b1;
        run_log(2*F + 15, -1, -1, -1);
        nd = 0; nt = 0;
        for (int c = 0; c < 2*F + 15; c++) begin nd += int'(log_deq[c]); nt += int'(log_done[c]); end
        checks++; if (nd !== 2 || log_deq[1] !== 1'b1 || log_deq[F + 4] !== 1'b1) begin errors++; $display("FAIL b2b_deq count=%0d exp=2", nd); end
        checks++; if (nt !== 2 || log_done[F + 4] !== 1'b1 || log_done[2*F + 7] !== 1'b1) begin errors++; $display("FAIL b2b_done count=%0d exp=2", nt); end
        checks++; if (!(log_done[F + 4] === 1'b1 && log_deq[F + 4] === 1'b1)) begin errors++; $display("FAIL b2b_deq_with_done deq=%b done=%b exp 1,1", log_deq[F + 4], log_done[F + 4]); end
        checks++; if (log_tx[F + 3] !== 1'b1 || log_tx[F + 4] !== 1'b1 || log_tx[F + 5] !== 1'b1 || log_tx[F + 6] !== 1'b0) begin errors++; $display("FAIL b2b_gap tx=%b%b%b%b exp=1110", log_tx[F + 3], log_tx[F + 4], log_tx[F + 5], log_tx[F + 6]); end
        for (int b = 0; b < NB; b++) begin
            ok = 1'b1;
            for (int k = 0; k < CPB; k++) begin
                if (log_tx[3 + b*CPB + k] !== frame_bit(8'h00, b)) ok = 1'b0;
                if (log_tx[F + 6 + b*CPB + k] !== frame_bit(8'hFF, b)) ok = 1'b0;
            end
            checks++; if (!ok) begin errors++; $display("FAIL b2b_tx_bit%0d got=%b/%b exp=%b/%b", b, log_tx[3 + b*CPB], log_tx[F + 6 + b*CPB], frame_bit(8'h00, b), frame_bit(8'hFF, b)); end
        end
    endtask

    task automatic test_empty();
        int nd, nb, nl;
        do_reset();
        enable = 1'b1;
        run_log(50, -1, -1, -1);
        nd = 0; nb = 0; nl = 0;
        for (int c = 0; c < 50; c++) begin
            nd += int'(log_deq[c]); nb += int'(log_busy[c]); nl += int'(log_tx[c] !== 1'b1);
        end
        checks++; if (nd !== 0) begin errors++; $display("FAIL empty_deq count=%0d exp=0", nd); end
        checks++; if (nl !== 0) begin errors++; $display("FAIL empty_tx low_cycles=%0d exp=0", nl); end
        checks++; if (nb !== 0) begin errors++; $display("FAIL empty_busy cycles=%0d exp=0", nb); end
    endtask

    task automatic test_enable_drop();
        int nd;
        logic ok;
        do_reset();
        q.push_back(8'h3C);
        q.push_back(8'h5A);
        fifo_empty = 1'b0;
        enable = 1'b1;
        run_log(63 + F + 5, 10, 60, -1);
        for (int b = 0; b < NB; b++) begin
            ok = 1'b1;
            for (int k = 0; k < CPB; k++) begin
                if (log_tx[3 + b*CPB + k] !== frame_bit(8'h3C, b)) ok = 1'b0;
                if (log_tx[63 + b*CPB + k] !== frame_bit(8'h5A, b)) ok = 1'b0;
            end
            checks++; if (!ok) begin errors++; $display("FAIL endrop_tx_bit%0d got=%b/%b exp=%b/%b", b, log_tx[3 + b*CPB], log_tx[63 + b*CPB], frame_bit(8'h3C, b), frame_bit(8'h5A, b)); end
        end
        nd = 0;
        for (int c = 2; c <= 60; c++) nd += int'(log_deq[c]);
        checks++; if (nd !== 0) begin errors++; $display("FAIL endrop_no_deq count=%0d exp=0", nd); end
        checks++; if (log_deq[61] !== 1'b1) begin errors++; $display("FAIL endrop_resume_deq got=%b exp=1", log_deq[61]); end
        checks++; if (log_done[F + 4] !== 1'b1 || log_done[63 + F + 1] !== 1'b1) begin errors++; $display("FAIL endrop_done got=%b/%b exp=1/1", log_done[F + 4], log_done[63 + F + 1]); end
        checks++; if (log_busy[F + 10] !== 1'b0 || log_tx[F + 10] !== 1'b1) begin errors++; $display("FAIL endrop_idle busy=%b tx=%b exp 0,1", log_busy[F + 10], log_tx[F + 10]); end
    endtask

    task automatic test_reset_mid();
        int nd, nb, nl;
        do_reset();
        q.push_back(8'hA5);
        fifo_empty = 1'b0;
        enable = 1'b1;
        run_log(50, -1, -1, 16);
        checks++; if (log_busy[16] !== 1'b1 || log_tx[16] !== 1'b1) begin errors++; $display("FAIL rstmid_inframe busy=%b tx=%b exp 1,1", log_busy[16], log_tx[16]); end
        checks++; if (log_tx[17] !== 1'b1 || log_busy[17] !== 1'b0 || log_done[17] !== 1'b0) begin errors++; $display("FAIL rstmid_after tx=%b busy=%b done=%b exp 1,0,0", log_tx[17], log_busy[17], log_done[17]); end
        nd = 0; nb = 0; nl = 0;
        for (int c = 17; c < 50; c++) begin
            nd += int'(log_deq[c]); nb += int'(log_busy[c]); nl += int'(log_tx[c] !== 1'b1);
        end
        checks++; if (nd !== 0 || nb !== 0 || nl !== 0) begin errors++; $display("FAIL rstmid_idle deq=%0d busy=%0d txlow=%0d exp 0,0,0", nd, nb, nl); end
    endtask

`ifdef FIFO_UART_TX_PARITY_EN
    task automatic test_parity();
        logic [10:0] exp_bits;
        logic ok;
        exp_bits = 11'b110_0000_1110;
        do_reset();
        q.push_back(8'h07);
        fifo_empty = 1'b0;
        enable = 1'b1;
        run_log(F + 10, -1, -1, -1);
        for (int b = 0; b < 11; b++) begin
            ok = 1'b1;
            for (int k = 0; k < CPB; k++) if (log_tx[3 + b*CPB + k] !== exp_bits[b]) ok = 1'b0;
            checks++; if (!ok) begin errors++; $display("FAIL parity_tx_bit%0d got=%b exp=%b", b, log_tx[3 + b*CPB], exp_bits[b]); end
        end
        checks++; if (log_tx[3 + 9*CPB] !== 1'b1) begin errors++; $display("FAIL parity_bit got=%b exp=1", log_tx[3 + 9*CPB]); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_empty();
        test_enable_drop();
        test_reset_mid();
`ifdef FIFO_UART_TX_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
